// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 64-bit RISC-V datapath: holds one decoded
// instruction, produces the ALU control code and forwards EX/MEM and MEM/WB results.
module id_ex_stage #(
  parameter int XLEN        = 64,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,

  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  input  logic                   flush,

  input  logic [XLEN-1:0]        rs1_data,
  input  logic [XLEN-1:0]        rs2_data,
  input  logic [XLEN-1:0]        imm,
  input  logic [4:0]             rs1_addr,
  input  logic [4:0]             rs2_addr,
  input  logic [4:0]             rd_addr,

  input  logic [1:0]             alu_op,
  input  logic [2:0]             funct3,
  input  logic                   funct7_b5,
  input  logic                   alu_src,

  input  logic                   reg_write,
  input  logic                   mem_read,
  input  logic                   mem_write,
  input  logic                   mem_to_reg,
  input  logic                   branch,

  input  logic                   exmem_reg_write,
  input  logic [4:0]             exmem_rd,
  input  logic [XLEN-1:0]        exmem_result,
  input  logic                   memwb_reg_write,
  input  logic [4:0]             memwb_rd,
  input  logic [XLEN-1:0]        memwb_result,

  output logic [XLEN-1:0]        alu_a,
  output logic [XLEN-1:0]        alu_b,
  output logic [3:0]             alu_control,
  output logic [XLEN-1:0]        store_data,

  output logic [4:0]             rd_q,
  output logic                   reg_write_q,
  output logic                   mem_read_q,
  output logic                   mem_write_q,
  output logic                   mem_to_reg_q,
  output logic                   branch_q,
  output logic                   illegal_q,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_BAD = 4'b1111;

  // Handshake: a beat moves across an interface on any rising edge where both
  // valid and ready are high. out_valid is held with stable payload until
  // out_ready; in_ready never depends on in_valid, and flush forces it low.

  logic                   valid_q,        valid_d;
  logic [XLEN-1:0]        rs1_data_q,     rs1_data_d;
  logic [XLEN-1:0]        rs2_data_q,     rs2_data_d;
  logic [XLEN-1:0]        imm_q,          imm_d;
  logic [4:0]             rs1_addr_q,     rs1_addr_d;
  logic [4:0]             rs2_addr_q,     rs2_addr_d;
  logic [4:0]             rd_d;
  logic                   alu_src_q,      alu_src_d;
  logic [3:0]             alu_control_q,  alu_control_d;
  logic                   reg_write_d;
  logic                   mem_read_d;
  logic                   mem_write_d;
  logic                   mem_to_reg_d;
  logic                   branch_d;
  logic                   illegal_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q,    stall_cnt_d;

  logic                   capture;
  logic                   stalled;
  logic [3:0]             dec_control;
  logic                   dec_illegal;
  logic [XLEN-1:0]        fwd_rs1;
  logic [XLEN-1:0]        fwd_rs2;

  assign in_ready  = !flush && (!valid_q || out_ready);
  assign capture   = in_valid && in_ready;
  assign stalled   = valid_q && !out_ready;
  assign out_valid = valid_q;

  // ALU control decode of the incoming beat; registered on capture.
  always_comb begin
    dec_control = ALU_BAD;
    dec_illegal = 1'b1;
    case (alu_op)
      2'b00: begin
        dec_control = ALU_ADD;
        dec_illegal = 1'b0;
      end
      2'b01: begin
        dec_control = ALU_SUB;
        dec_illegal = 1'b0;
      end
      default: begin
        case (funct3)
          3'b000: begin
            // Only R-type honours funct7 bit 5; ADDI has no subtract form.
            dec_control = (alu_op == 2'b10 && funct7_b5) ? ALU_SUB : ALU_ADD;
            dec_illegal = 1'b0;
          end
          3'b111: begin
            dec_control = ALU_AND;
            dec_illegal = 1'b0;
          end
          3'b110: begin
            dec_control = ALU_OR;
            dec_illegal = 1'b0;
          end
          default: begin
            dec_control = ALU_BAD;
            dec_illegal = 1'b1;
          end
        endcase
      end
    endcase
  end

  // Next-state selection: flush beats capture, capture beats drain/hold.
  always_comb begin
    valid_d       = valid_q;
    rs1_data_d    = rs1_data_q;
    rs2_data_d    = rs2_data_q;
    imm_d         = imm_q;
    rs1_addr_d    = rs1_addr_q;
    rs2_addr_d    = rs2_addr_q;
    rd_d          = rd_q;
    alu_src_d     = alu_src_q;
    alu_control_d = alu_control_q;
    reg_write_d   = reg_write_q;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;
    mem_to_reg_d  = mem_to_reg_q;
    branch_d      = branch_q;
    illegal_d     = illegal_q;

    if (flush) begin
      valid_d      = 1'b0;
      reg_write_d  = 1'b0;
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
      mem_to_reg_d = 1'b0;
      branch_d     = 1'b0;
      illegal_d    = 1'b0;
    end else if (capture) begin
      valid_d       = 1'b1;
      rs1_data_d    = rs1_data;
      rs2_data_d    = rs2_data;
      imm_d         = imm;
      rs1_addr_d    = rs1_addr;
      rs2_addr_d    = rs2_addr;
      rd_d          = rd_addr;
      alu_src_d     = alu_src;
      alu_control_d = dec_control;
      reg_write_d   = reg_write;
      mem_read_d    = mem_read;
      mem_write_d   = mem_write;
      mem_to_reg_d  = mem_to_reg;
      branch_d      = branch;
      illegal_d     = dec_illegal;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Backpressure counter keeps counting through a flush and sticks at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stalled && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q       <= 1'b0;
      rs1_data_q    <= '0;
      rs2_data_q    <= '0;
      imm_q         <= '0;
      rs1_addr_q    <= '0;
      rs2_addr_q    <= '0;
      rd_q          <= '0;
      alu_src_q     <= 1'b0;
      alu_control_q <= '0;
      reg_write_q   <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_to_reg_q  <= 1'b0;
      branch_q      <= 1'b0;
      illegal_q     <= 1'b0;
      stall_cnt_q   <= '0;
    end else begin
      valid_q       <= valid_d;
      rs1_data_q    <= rs1_data_d;
      rs2_data_q    <= rs2_data_d;
      imm_q         <= imm_d;
      rs1_addr_q    <= rs1_addr_d;
      rs2_addr_q    <= rs2_addr_d;
      rd_q          <= rd_d;
      alu_src_q     <= alu_src_d;
      alu_control_q <= alu_control_d;
      reg_write_q   <= reg_write_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_to_reg_q  <= mem_to_reg_d;
      branch_q      <= branch_d;
      illegal_q     <= illegal_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  // Forwarding: EX/MEM is the younger producer so it wins; x0 is hardwired zero.
  always_comb begin
    fwd_rs1 = rs1_data_q;
    if (exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == rs1_addr_q)) begin
      fwd_rs1 = exmem_result;
    end else if (memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == rs1_addr_q)) begin
      fwd_rs1 = memwb_result;
    end
  end

  always_comb begin
    fwd_rs2 = rs2_data_q;
    if (exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == rs2_addr_q)) begin
      fwd_rs2 = exmem_result;
    end else if (memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == rs2_addr_q)) begin
      fwd_rs2 = memwb_result;
    end
  end

  assign alu_a       = fwd_rs1;
  assign store_data  = fwd_rs2;
  assign alu_b       = alu_src_q ? imm_q : fwd_rs2;
  assign alu_control = alu_control_q;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed steps followed by a random
// phase, all compared against a one-entry transaction model of the stage.
module tb_id_ex_stage;
  localparam int XLEN = 64;
  localparam int SW   = 4;
  localparam logic [SW-1:0] STALL_MAX = {SW{1'b1}};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // ---------------- DUT signals ----------------
  logic in_valid, in_ready, out_valid, out_ready, flush;
  logic [XLEN-1:0] rs1_data, rs2_data, imm;
  logic [4:0] rs1_addr, rs2_addr, rd_addr;
  logic [1:0] alu_op;
  logic [2:0] funct3;
  logic funct7_b5, alu_src;
  logic reg_write, mem_read, mem_write, mem_to_reg, branch;
  logic exmem_reg_write, memwb_reg_write;
  logic [4:0] exmem_rd, memwb_rd;
  logic [XLEN-1:0] exmem_result, memwb_result;
  logic [XLEN-1:0] alu_a, alu_b, store_data;
  logic [3:0] alu_control;
  logic [4:0] rd_q;
  logic reg_write_q, mem_read_q, mem_write_q, mem_to_reg_q, branch_q, illegal_q;
  logic [SW-1:0] stall_cnt;

  id_ex_stage #(.XLEN(XLEN), .STALL_CNT_W(SW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .flush(flush),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
    .alu_op(alu_op), .funct3(funct3), .funct7_b5(funct7_b5), .alu_src(alu_src),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .mem_to_reg(mem_to_reg), .branch(branch),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control), .store_data(store_data),
    .rd_q(rd_q), .reg_write_q(reg_write_q), .mem_read_q(mem_read_q),
    .mem_write_q(mem_write_q), .mem_to_reg_q(mem_to_reg_q), .branch_q(branch_q),
    .illegal_q(illegal_q), .stall_cnt(stall_cnt)
  );

  // ---------------- scoreboard counters ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model: the one held instruction ----------------
  logic            m_valid;
  logic [4:0]      m_rs1_addr, m_rs2_addr, m_rd;
  logic [XLEN-1:0] m_rs1_data, m_rs2_data, m_imm;
  logic            m_alu_src;
  logic [4:0]      m_ctl;      // reg_write, mem_read, mem_write, mem_to_reg, branch
  logic [3:0]      m_code;
  logic            m_ill;
  logic [SW-1:0]   m_stall;
  logic            m_ctrl_known, m_data_known;

  // Returns {illegal, code} from the decode rules.
  function automatic logic [4:0] ref_decode(input logic [1:0] op, input logic [2:0] f3, input logic f7);
    if (op == 2'b00) return {1'b0, 4'b0010};
    if (op == 2'b01) return {1'b0, 4'b0110};
    if (f3 == 3'b111) return {1'b0, 4'b0000};
    if (f3 == 3'b110) return {1'b0, 4'b0001};
    if (f3 == 3'b000) return (op == 2'b10 && f7) ? {1'b0, 4'b0110} : {1'b0, 4'b0010};
    return {1'b1, 4'b1111};
  endfunction

  function automatic logic [XLEN-1:0] ref_fwd(input logic [4:0] a, input logic [XLEN-1:0] d);
    if (a == 5'd0) return d;
    if (exmem_reg_write && exmem_rd == a) return exmem_result;
    if (memwb_reg_write && memwb_rd == a) return memwb_result;
    return d;
  endfunction

  // Advance the model with the inputs that were stable across the edge.
  task automatic model_edge();
    logic rdy;
    logic [4:0] dec;
    if (!rst_n) begin
      m_valid = 0; m_rs1_addr = 0; m_rs2_addr = 0; m_rd = 0;
      m_rs1_data = 0; m_rs2_data = 0; m_imm = 0; m_alu_src = 0;
      m_ctl = 0; m_code = 0; m_ill = 0; m_stall = 0;
      m_ctrl_known = 1; m_data_known = 1;
      return;
    end
    if (m_valid && !out_ready && m_stall != STALL_MAX) m_stall = m_stall + 1'b1;
    rdy = !flush && (!m_valid || out_ready);
    if (flush) begin
      m_valid = 0; m_ctl = 0; m_ill = 0;
      m_ctrl_known = 1; m_data_known = 0;
    end else if (in_valid && rdy) begin
      dec = ref_decode(alu_op, funct3, funct7_b5);
      m_valid = 1;
      m_rs1_addr = rs1_addr; m_rs2_addr = rs2_addr; m_rd = rd_addr;
      m_rs1_data = rs1_data; m_rs2_data = rs2_data; m_imm = imm; m_alu_src = alu_src;
      m_ctl = {reg_write, mem_read, mem_write, mem_to_reg, branch};
      m_code = dec[3:0]; m_ill = dec[4];
      m_ctrl_known = 1; m_data_known = 1;
    end else if (m_valid && out_ready) begin
      m_valid = 0; m_ctrl_known = 0; m_data_known = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_all();
    #1;
    chk("out_valid", out_valid, m_valid);
    chk("in_ready", in_ready, !flush && (!m_valid || out_ready));
    chk("stall_cnt", stall_cnt, m_stall);
    if (m_ctrl_known) begin
      chk("ctl_q", {reg_write_q, mem_read_q, mem_write_q, mem_to_reg_q, branch_q}, m_ctl);
      chk("illegal_q", illegal_q, m_ill);
    end
    if (m_data_known) begin
      chk("rd_q", rd_q, m_rd);
      chk("alu_control", alu_control, m_code);
      chk("alu_a", alu_a, ref_fwd(m_rs1_addr, m_rs1_data));
      chk("store_data", store_data, ref_fwd(m_rs2_addr, m_rs2_data));
      chk("alu_b", alu_b, m_alu_src ? m_imm : ref_fwd(m_rs2_addr, m_rs2_data));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_fwd();
    exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
    memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
  endtask

  task automatic set_beat(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                          input logic [4:0] a1, input logic [63:0] d1,
                          input logic [4:0] a2, input logic [63:0] d2,
                          input logic [63:0] im, input logic src,
                          input logic [4:0] rd, input logic [4:0] ctl);
    alu_op = op; funct3 = f3; funct7_b5 = f7;
    rs1_addr = a1; rs1_data = d1; rs2_addr = a2; rs2_data = d2;
    imm = im; alu_src = src; rd_addr = rd;
    {reg_write, mem_read, mem_write, mem_to_reg, branch} = ctl;
  endtask

  task automatic do_reset();
    rst_n = 0;
    tick(); tick();
    rst_n = 1;
  endtask

  task automatic random_inputs();
    in_valid  = ($urandom_range(0, 3) != 0);
    out_ready = ($urandom_range(0, 2) != 0);
    flush     = ($urandom_range(0, 9) == 0);
    set_beat(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 3)), {$urandom, $urandom},
             5'($urandom_range(0, 3)), {$urandom, $urandom},
             {$urandom, $urandom}, 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    exmem_reg_write = 1'($urandom_range(0, 1));
    exmem_rd        = 5'($urandom_range(0, 3));
    exmem_result    = {$urandom, $urandom};
    memwb_reg_write = 1'($urandom_range(0, 1));
    memwb_rd        = 5'($urandom_range(0, 3));
    memwb_result    = {$urandom, $urandom};
  endtask

  // ---------------- decode sweep table ----------------
  logic [1:0] t_op  [0:6] = '{2'b10, 2'b11, 2'b10, 2'b10, 2'b11, 2'b00, 2'b01};
  logic [2:0] t_f3  [0:6] = '{3'b000, 3'b000, 3'b100, 3'b111, 3'b110, 3'b101, 3'b011};
  logic       t_f7  [0:6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [3:0] t_exp [0:6] = '{4'b0110, 4'b0010, 4'b1111, 4'b0000, 4'b0001, 4'b0010, 4'b0110};
  logic       t_ill [0:6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  // ---------------- directed steps, then random ----------------
  initial begin
    rst_n = 0; in_valid = 0; out_ready = 1; flush = 0;
    set_beat(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    clear_fwd();

    // Reset
    do_reset();
    check_all();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_stall", stall_cnt, 0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_store", store_data, 0);
    chk("rst_alu_control", alu_control, 4'b0000);
    chk("rst_ctl", {reg_write_q, mem_read_q, mem_write_q, mem_to_reg_q, branch_q, illegal_q}, 0);

    // Decode sweep, back-to-back captures
    out_ready = 1; in_valid = 1;
    for (int i = 0; i < 7; i++) begin
      set_beat(t_op[i], t_f3[i], t_f7[i], 1, 64'h10 + 64'(i), 2, 64'h20, 64'h30, 0, 5'(i + 1), 5'b10000);
      tick();
      check_all();
      chk("dec_code", alu_control, t_exp[i]);
      chk("dec_illegal", illegal_q, t_ill[i]);
      chk("dec_valid", out_valid, 1'b1);
    end

    // Forward priority on rs1
    set_beat(2'b00, 0, 0, 5, 64'h11, 6, 64'h22, 64'h33, 0, 3, 5'b10000);
    tick();
    in_valid = 0; out_ready = 0;
    exmem_reg_write = 1; exmem_rd = 5; exmem_result = 64'hAA;
    memwb_reg_write = 1; memwb_rd = 5; memwb_result = 64'hBB;
    check_all();
    chk("fwd_exmem", alu_a, 64'hAA);
    exmem_reg_write = 0;
    check_all();
    chk("fwd_memwb", alu_a, 64'hBB);
    memwb_reg_write = 0;
    check_all();
    chk("fwd_none", alu_a, 64'h11);

    // x0 guard on rs2
    clear_fwd();
    out_ready = 1; in_valid = 1;
    set_beat(2'b10, 0, 0, 1, 64'h5, 0, 0, 64'h77, 0, 4, 5'b10000);
    tick();
    in_valid = 0; out_ready = 0;
    exmem_reg_write = 1; exmem_rd = 0; exmem_result = 64'hFF;
    memwb_reg_write = 1; memwb_rd = 0; memwb_result = 64'hEE;
    check_all();
    chk("x0_alu_b", alu_b, 0);
    chk("x0_store", store_data, 0);
    clear_fwd();

    // Backpressure
    do_reset();
    out_ready = 1; in_valid = 1;
    set_beat(2'b00, 0, 0, 1, 64'hA1, 2, 64'hA2, 64'hA3, 1, 7, 5'b10100);
    tick();
    out_ready = 0;
    set_beat(2'b01, 0, 0, 3, 64'hB1, 4, 64'hB2, 64'hB3, 0, 9, 5'b10100);
    for (int i = 0; i < 5; i++) begin
      check_all();
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_rd_hold", rd_q, 7);
      chk("bp_alu_b_hold", alu_b, 64'hA3);
      tick();
    end
    check_all();
    chk("bp_stall5", stall_cnt, 5);
    out_ready = 1;
    check_all();
    chk("bp_ready_up", in_ready, 1'b1);
    tick();
    check_all();
    chk("bp_b_valid", out_valid, 1'b1);
    chk("bp_b_rd", rd_q, 9);

    // Flush while stalled, with a pending beat on the input
    out_ready = 0; in_valid = 1; flush = 1;
    set_beat(2'b00, 0, 0, 1, 1, 1, 1, 1, 0, 12, 5'b11111);
    check_all();
    chk("fl_in_ready", in_ready, 1'b0);
    tick();
    flush = 0; in_valid = 0;
    check_all();
    chk("fl_valid", out_valid, 1'b0);
    chk("fl_reg_write", reg_write_q, 1'b0);
    chk("fl_mem_write", mem_write_q, 1'b0);
    chk("fl_stall", stall_cnt, 6);
    out_ready = 1; in_valid = 1;
    set_beat(2'b00, 0, 0, 1, 1, 2, 2, 3, 1, 13, 5'b10000);
    tick();
    in_valid = 0;
    check_all();
    chk("fl_next_valid", out_valid, 1'b1);
    chk("fl_next_rd", rd_q, 13);

    // Saturation, then reset discards a stalled instruction
    out_ready = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      check_all();
    end
    chk("sat_stall", stall_cnt, STALL_MAX);
    rst_n = 0;
    tick();
    rst_n = 1;
    check_all();
    chk("rst_stalled_valid", out_valid, 1'b0);
    chk("rst_stalled_cnt", stall_cnt, 0);

    // Random phase
    for (int i = 0; i < 600; i++) begin
      random_inputs();
      check_all();
      tick();
    end
    check_all();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
